// File: rtl/rcc_pkg.sv
// Shared RCC definitions: reset-controller state encoding and reset-cause flag layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rcc_pkg;

  typedef enum logic [1:0] {
    RST_RUN    = 2'd0,
    RST_ASSERT = 2'd1,
    RST_HOLD   = 2'd2,
    RST_SETTLE = 2'd3
  } rcc_rst_state_e;

  localparam int RST_FLAG_W    = 6;
  localparam int RST_FLAG_POR  = 0;
  localparam int RST_FLAG_PIN  = 1;
  localparam int RST_FLAG_SW   = 2;
  localparam int RST_FLAG_IWDG = 3;
  localparam int RST_FLAG_WWDG = 4;
  localparam int RST_FLAG_LPWR = 5;

  // Larger of two cycle counts; sizes the shared ASSERT/SETTLE counter.
  function automatic int rcc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rcc_rst_ctrl.sv
// System reset controller: merges reset requests into a min-width sys_rst_n pulse plus settle window.
// Latency: request sampled at edge N drives sys_rst_n low and rst_busy high right after edge N.
// Backpressure: none; requests arriving mid-sequence only set flags or restart from SETTLE.
module rcc_rst_ctrl
  import rcc_pkg::*;
#(
  parameter int PULSE_CYC  = 32,
  parameter int SETTLE_CYC = 8,
  parameter int CNT_W      = $clog2(rcc_max(PULSE_CYC, SETTLE_CYC) + 1)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  pin_rst_req,
  input  logic                  sw_rst_req,
  input  logic                  iwdg_rst_req,
  input  logic                  wwdg_rst_req,
  input  logic                  lpwr_rst_req,
  input  logic                  rmvf,
  output logic                  sys_rst_n,
  output logic                  rst_busy,
  output logic [RST_FLAG_W-1:0] rst_flags
);

  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  rcc_rst_state_e        state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  sys_rst_n_q;
  logic                  rst_busy_q;
  logic [RST_FLAG_W-1:0] flags_q;
  logic [RST_FLAG_W-1:0] flags_d;
  logic                  req_any;

  assign req_any = pin_rst_req | sw_rst_req | iwdg_rst_req | wwdg_rst_req | lpwr_rst_req;

  // Reset sequencer; outputs are registered from the state being entered so they track it with no lag.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= RST_ASSERT;
      cnt_q       <= '0;
      sys_rst_n_q <= 1'b0;
      rst_busy_q  <= 1'b1;
    end else begin
      case (state_q)
        RST_RUN: begin
          if (req_any) begin
            state_q     <= RST_ASSERT;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b0;
            rst_busy_q  <= 1'b1;
          end
        end
        RST_ASSERT: begin
          // Pulse requests here only land in the flags; the pulse width is fixed once started.
          if (cnt_q == PULSE_LAST) begin
            cnt_q <= '0;
            if (pin_rst_req) begin
              state_q <= RST_HOLD;
            end else begin
              state_q     <= RST_SETTLE;
              sys_rst_n_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RST_HOLD: begin
          if (!pin_rst_req) begin
            state_q     <= RST_SETTLE;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b1;
          end
        end
        RST_SETTLE: begin
          if (req_any) begin
            state_q     <= RST_ASSERT;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_q    <= RST_RUN;
            cnt_q      <= '0;
            rst_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q     <= RST_ASSERT;
          cnt_q       <= '0;
          sys_rst_n_q <= 1'b0;
          rst_busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Sticky cause flags: clear first, then OR in this cycle's requests so a set beats a clear.
  always_comb begin
    flags_d = flags_q;
    if (rmvf) begin
      flags_d = '0;
    end
    flags_d[RST_FLAG_PIN]  = flags_d[RST_FLAG_PIN]  | pin_rst_req;
    flags_d[RST_FLAG_SW]   = flags_d[RST_FLAG_SW]   | sw_rst_req;
    flags_d[RST_FLAG_IWDG] = flags_d[RST_FLAG_IWDG] | iwdg_rst_req;
    flags_d[RST_FLAG_WWDG] = flags_d[RST_FLAG_WWDG] | wwdg_rst_req;
    flags_d[RST_FLAG_LPWR] = flags_d[RST_FLAG_LPWR] | lpwr_rst_req;
  end

  // Flag register; power-on reset leaves only the por cause recorded.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      flags_q               <= '0;
      flags_q[RST_FLAG_POR] <= 1'b1;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign sys_rst_n = sys_rst_n_q;
  assign rst_busy  = rst_busy_q;
  assign rst_flags = flags_q;

endmodule

// File: tb/tb_rcc_rst_ctrl.sv
// Bench for rcc_rst_ctrl: directed scenarios with literal expectations, then randomized traffic.
// Every cycle the DUT outputs are compared against a remaining-cycles reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rcc_rst_ctrl;

  localparam int P = 32;
  localparam int S = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       pin_rst_req = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       iwdg_rst_req = 1'b0;
  logic       wwdg_rst_req = 1'b0;
  logic       lpwr_rst_req = 1'b0;
  logic       rmvf = 1'b0;
  logic       sys_rst_n;
  logic       rst_busy;
  logic [5:0] rst_flags;

  int checks = 0;
  int failures = 0;

  rcc_rst_ctrl #(.PULSE_CYC(P), .SETTLE_CYC(S)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .pin_rst_req  (pin_rst_req),
    .sw_rst_req   (sw_rst_req),
    .iwdg_rst_req (iwdg_rst_req),
    .wwdg_rst_req (wwdg_rst_req),
    .lpwr_rst_req (lpwr_rst_req),
    .rmvf         (rmvf),
    .sys_rst_n    (sys_rst_n),
    .rst_busy     (rst_busy),
    .rst_flags    (rst_flags)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: the reset is "low" for at least P cycles (longer while the pin is held),
  // then "busy" for S more cycles; any request during that tail starts a fresh low period.
  bit       m_valid = 1'b0;
  bit       m_lo = 1'b1;
  int       m_lo_rem = 0;
  int       m_settle = 0;
  bit [5:0] m_flags = 6'h01;

  always @(posedge sys_clk) begin
    bit req;
    req = pin_rst_req | sw_rst_req | iwdg_rst_req | wwdg_rst_req | lpwr_rst_req;
    if (sys_rst) begin
      m_valid  = 1'b1;
      m_lo     = 1'b1;
      m_lo_rem = P;
      m_settle = 0;
      m_flags  = 6'h01;
    end else begin
      m_flags = (rmvf ? 6'h00 : m_flags)
              | {lpwr_rst_req, wwdg_rst_req, iwdg_rst_req, sw_rst_req, pin_rst_req, 1'b0};
      if (m_lo) begin
        if (m_lo_rem > 1) m_lo_rem--;
        else if (pin_rst_req) m_lo_rem = 0;
        else begin
          m_lo     = 1'b0;
          m_settle = S;
        end
      end else if (req) begin
        m_lo     = 1'b1;
        m_lo_rem = P;
        m_settle = 0;
      end else if (m_settle > 0) begin
        m_settle--;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (m_valid) begin
      check("model_sys_rst_n", int'(sys_rst_n), int'(!m_lo));
      check("model_rst_busy", int'(rst_busy), int'(m_lo || (m_settle > 0)));
      check("model_rst_flags", int'(rst_flags), int'(m_flags));
    end
  end

  bit busy_dropped;

  // Counts falling edges while sys_rst_n stays low, starting at the current one.
  task automatic count_low(output int n);
    n = 0;
    while (!sys_rst_n && n < 400) begin
      if (!rst_busy) busy_dropped = 1'b1;
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rst_busy && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    check("idle_timeout", int'(rst_busy), 0);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic clear_flags();
    rmvf = 1'b1;
    @(negedge sys_clk);
    rmvf = 1'b0;
  endtask

  initial begin
    int n;
    int pin_left;

    // Power-on: 5 cycles of sys_rst.
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b0;
    check("por_rst_n_low", int'(sys_rst_n), 0);
    check("por_busy", int'(rst_busy), 1);
    count_low(n);
    check("por_low_width", n, P);
    n = 0;
    while (sys_rst_n && rst_busy && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check("por_settle_width", n, S);
    check("por_flags", int'(rst_flags), 6'h01);
    repeat (3) @(negedge sys_clk);

    // Software reset.
    clear_flags();
    check("rmvf_clears", int'(rst_flags), 0);
    sw_rst_req = 1'b1;
    @(negedge sys_clk);
    sw_rst_req = 1'b0;
    count_low(n);
    check("sw_low_width", n, P);
    check("sw_flags", int'(rst_flags), 6'h04);
    wait_idle();

    // Long pin reset, 100 cycles.
    clear_flags();
    pin_rst_req = 1'b1;
    n = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (!sys_rst_n) n++;
    end
    check("pin_low_while_held", n, 100);
    pin_rst_req = 1'b0;
    check("pin_low_at_release", int'(sys_rst_n), 0);
    @(negedge sys_clk);
    check("pin_high_after_release", int'(sys_rst_n), 1);
    check("pin_flag", int'(rst_flags[1]), 1);
    n = 0;
    while (sys_rst_n && rst_busy && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check("pin_settle_width", n, S);
    wait_idle();

    // Watchdog pulse in the middle of an sw-reset pulse.
    clear_flags();
    sw_rst_req = 1'b1;
    @(negedge sys_clk);
    sw_rst_req = 1'b0;
    n = 0;
    while (!sys_rst_n && n < 400) begin
      iwdg_rst_req = (n == 10);
      @(negedge sys_clk);
      n++;
    end
    iwdg_rst_req = 1'b0;
    check("assert_req_width", n, P);
    check("assert_req_flags", int'(rst_flags), 6'h0C);
    wait_idle();

    // Watchdog pulse during SETTLE restarts a full pulse.
    busy_dropped = 1'b0;
    sw_rst_req = 1'b1;
    @(negedge sys_clk);
    sw_rst_req = 1'b0;
    count_low(n);
    repeat (3) begin
      if (!rst_busy) busy_dropped = 1'b1;
      @(negedge sys_clk);
    end
    wwdg_rst_req = 1'b1;
    @(negedge sys_clk);
    wwdg_rst_req = 1'b0;
    check("settle_req_restarts", int'(sys_rst_n), 0);
    count_low(n);
    check("settle_req_width", n, P);
    check("settle_busy_held", int'(busy_dropped), 0);
    wait_idle();

    // Clear and set in the same cycle.
    rmvf = 1'b1;
    lpwr_rst_req = 1'b1;
    @(negedge sys_clk);
    rmvf = 1'b0;
    lpwr_rst_req = 1'b0;
    check("collision_flags", int'(rst_flags), 6'h20);
    wait_idle();

    // Randomized traffic, including mid-operation power-on resets.
    pin_left = 0;
    repeat (4000) begin
      sys_rst      = ($urandom_range(0, 499) == 0);
      sw_rst_req   = ($urandom_range(0, 199) == 0);
      iwdg_rst_req = ($urandom_range(0, 249) == 0);
      wwdg_rst_req = ($urandom_range(0, 249) == 0);
      lpwr_rst_req = ($urandom_range(0, 299) == 0);
      rmvf         = ($urandom_range(0, 39) == 0);
      if (pin_left > 0) pin_left--;
      else if ($urandom_range(0, 299) == 0) pin_left = $urandom_range(1, 60);
      pin_rst_req = (pin_left > 0);
      @(negedge sys_clk);
    end
    sys_rst = 1'b0;
    sw_rst_req = 1'b0;
    iwdg_rst_req = 1'b0;
    wwdg_rst_req = 1'b0;
    lpwr_rst_req = 1'b0;
    rmvf = 1'b0;
    pin_rst_req = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
